// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, PC width, fetch FSM states and the
// backward-taken branch target helper.
package cpu_pkg;
    localparam int PC_W = 16;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Branch target: PC of the branch + 2 + sign-extended 9-bit word offset.
    function automatic logic [PC_W-1:0] btfn_target(input logic [PC_W-1:0] pc_in,
                                                    input logic [8:0]      off);
        return pc_in + 16'd2 + {{6{off[8]}}, off, 1'b0};
    endfunction
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks an instruction word returning from
// memory while the pipeline is stalled.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [15:0]     i_data,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    output logic [15:0]     o_data,
    output logic [PC_W-1:0] o_pc
);
    logic            r_valid;
    logic [15:0]     r_data;
    logic [PC_W-1:0] r_pc;

    // Clear (redirect) beats a load issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
            r_pc   <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with one in-flight request, stall skid buffer and
// halt detection. Define FETCH_BTFN_EN for backward-taken static prediction.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [15:0] redir_pc,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_pred_taken,
    output logic        hlt,
    output logic [15:0] pc
);
    fetch_state_t    r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic            r_inf_valid, w_inf_valid_next;
    logic [PC_W-1:0] r_inf_pc, w_inf_pc_next;
    logic            r_ifid_valid, w_ifid_valid_next;
    logic [15:0]     r_ifid_instr, w_ifid_instr_next;
    logic [PC_W-1:0] r_ifid_pc, w_ifid_pc_next;
`ifdef FETCH_BTFN_EN
    logic            r_ifid_pred, w_ifid_pred_next;
`endif

    logic            w_skid_load, w_skid_drain, w_skid_clear, w_skid_valid;
    logic [15:0]     w_skid_data;
    logic [PC_W-1:0] w_skid_pc;
    logic            w_load;
    logic [15:0]     w_load_instr;
    logic [PC_W-1:0] w_load_pc;

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clear),
        .i_data  (imem_rdata),
        .i_pc    (r_inf_pc),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc)
    );

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_inf_valid_next  = r_inf_valid;
        w_inf_pc_next     = r_inf_pc;
        w_ifid_valid_next = r_ifid_valid;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc_next    = r_ifid_pc;
`ifdef FETCH_BTFN_EN
        w_ifid_pred_next  = r_ifid_pred;
`endif
        w_skid_load       = 1'b0;
        w_skid_drain      = 1'b0;
        w_skid_clear      = 1'b0;
        w_load            = 1'b0;
        w_load_instr      = imem_rdata;
        w_load_pc         = r_inf_pc;

        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_pc_next         = r_pc + 16'd2;
                    w_inf_valid_next  = 1'b1;
                    w_inf_pc_next     = r_pc;
                    w_load            = r_inf_valid;
                    w_ifid_valid_next = r_inf_valid;
                end else if (r_inf_valid) begin
                    // Word arriving under stall must not be lost: park it.
                    w_skid_load      = 1'b1;
                    w_inf_valid_next = 1'b0;
                    w_state_next     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    w_skid_drain      = 1'b1;
                    w_load            = w_skid_valid;
                    w_load_instr      = w_skid_data;
                    w_load_pc         = w_skid_pc;
                    w_ifid_valid_next = w_skid_valid;
                    w_state_next      = ST_RUN;
                end
            end
            ST_HALT: begin
                w_inf_valid_next = 1'b0;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        if (w_load) begin
            w_ifid_instr_next = w_load_instr;
            w_ifid_pc_next    = w_load_pc;
`ifdef FETCH_BTFN_EN
            w_ifid_pred_next  = 1'b0;
`endif
            if (w_load_instr[15:12] == OP_HLT) begin
                w_state_next     = ST_HALT;
                w_inf_valid_next = 1'b0;
            end
`ifdef FETCH_BTFN_EN
            else if (w_load_instr[15:12] == OP_B && w_load_instr[8]) begin
                w_ifid_pred_next = 1'b1;
                w_pc_next        = btfn_target(w_load_pc, w_load_instr[8:0]);
                w_inf_valid_next = 1'b0;
            end
`endif
        end

        // Execute-stage redirect outranks stall, halt and prediction.
        if (redir_valid) begin
            w_pc_next         = redir_pc;
            w_inf_valid_next  = 1'b0;
            w_skid_load       = 1'b0;
            w_skid_drain      = 1'b0;
            w_skid_clear      = 1'b1;
            w_ifid_valid_next = 1'b0;
            w_state_next      = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_inf_valid  <= 1'b0;
            r_inf_pc     <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_inf_valid  <= w_inf_valid_next;
            r_inf_pc     <= w_inf_pc_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc    <= w_ifid_pc_next;
        end
    end

`ifdef FETCH_BTFN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_pred <= 1'b0;
        end else begin
            r_ifid_pred <= w_ifid_pred_next;
        end
    end
    assign ifid_pred_taken = r_ifid_pred;
`else
    assign ifid_pred_taken = 1'b0;
`endif

    assign imem_en       = (r_state == ST_RUN) && !stall && !rst;
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign hlt           = (r_state == ST_HALT);
    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus2 = r_ifid_pc + 16'd2;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pins plus randomized stall/redirect/reset
// traffic checked every cycle against a queue-based fetch model.
module tb_fetch_stage;
    logic        clk, rst, stall, redir_valid;
    logic [15:0] redir_pc, imem_addr, imem_rdata;
    logic        imem_en, ifid_valid, ifid_pred_taken, hlt;
    logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus2, pc;

`ifdef FETCH_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redir_valid     (redir_valid),
        .redir_pc        (redir_pc),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus2   (ifid_pc_plus2),
        .ifid_pred_taken (ifid_pred_taken),
        .hlt             (hlt),
        .pc              (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: one-cycle registered read, junk when not enabled.
    logic [15:0] mem [0:32767];
    always @(posedge clk) begin
        if (imem_en === 1'b1) imem_rdata <= mem[imem_addr[15:1]];
        else                  imem_rdata <= 16'hDEAD;
    end

    // Model: words fetched but not yet in IF/ID, in program order. A word
    // that has sat through a stall cycle is "waited"; draining it costs the
    // fetch slot of that cycle.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] w;
        bit          waited;
    } ent_t;
    ent_t        q[$];
    ent_t        m_e, m_new;
    bit          m_live = 1'b0;
    logic [15:0] m_pc;
    bit          m_halted, m_v, m_pred, m_loaded, m_issue;
    logic [15:0] m_instr, m_ipc;
    int          m_off;

    function automatic bit exp_en();
        return !rst && !m_halted && !stall && !(q.size() > 0 && q[0].waited);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_pc = 16'h0000; q.delete(); m_halted = 1'b0;
            m_v = 1'b0; m_instr = 16'h0; m_ipc = 16'h0; m_pred = 1'b0;
        end else if (m_live) begin
            if (redir_valid) begin
                m_pc = redir_pc; q.delete(); m_v = 1'b0; m_halted = 1'b0;
            end else if (m_halted) begin
                q.delete();
            end else if (stall) begin
                foreach (q[i]) q[i].waited = 1'b1;
            end else begin
                m_issue  = exp_en();
                m_loaded = 1'b0;
                if (q.size() > 0) begin
                    m_e = q.pop_front();
                    m_v = 1'b1; m_instr = m_e.w; m_ipc = m_e.pc; m_pred = 1'b0;
                    m_loaded = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
                if (m_issue) begin
                    m_new.pc = m_pc; m_new.w = mem[m_pc[15:1]]; m_new.waited = 1'b0;
                    q.push_back(m_new);
                    m_pc = m_pc + 16'd2;
                end
                if (m_loaded) begin
                    if (m_e.w[15:12] == 4'hF) begin
                        m_halted = 1'b1; q.delete();
                    end
`ifdef FETCH_BTFN_EN
                    else if (m_e.w[15:12] == 4'hC && m_e.w[8]) begin
                        m_off = int'(m_e.w[8:0]);
                        if (m_off >= 256) m_off = m_off - 512;
                        m_pred = 1'b1;
                        m_pc = 16'(int'(m_e.pc) + 2 + 2 * m_off);
                        q.delete();
                    end
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_en", {15'd0, imem_en}, {15'd0, exp_en()});
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("hlt", {15'd0, hlt}, {15'd0, m_halted});
            chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_v});
            if (m_v) begin
                chk("ifid_instr", ifid_instr, m_instr);
                chk("ifid_pc", ifid_pc, m_ipc);
                chk("ifid_pc_plus2", ifid_pc_plus2, m_ipc + 16'd2);
                chk("ifid_pred", {15'd0, ifid_pred_taken}, {15'd0, m_pred});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            logic [14:0] ix;
            ix = 15'(i);
            mem[i] = {4'h1, ix[3:0], ix[11:4]};
        end
        mem[16'h0006 >> 1] = 16'hF000;
        mem[16'h0010 >> 1] = 16'hC1FE;
        mem[16'h0020 >> 1] = 16'hC002;
        for (int i = 16'h0200 >> 1; i < (16'h0300 >> 1); i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k == 0)      mem[i] = {4'hF, 12'($urandom)};
            else if (k < 3)  mem[i] = {4'hC, 12'($urandom)};
            else             mem[i] = {4'($urandom_range(1, 7)), 12'($urandom)};
        end

        rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = 16'h0;
        wait_cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ifid_valid", {15'd0, ifid_valid}, 16'd0);
        chk("rst_ifid_instr", ifid_instr, 16'h0000);
        chk("rst_ifid_pc", ifid_pc, 16'h0000);
        chk("rst_hlt", {15'd0, hlt}, 16'd0);
        chk("first_fetch_en", {15'd0, imem_en}, 16'd1);
        chk("first_fetch_pc", pc, 16'h0000);
        wait_cyc(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("seq_pc", ifid_pc, 16'(i * 2));
            chk("seq_instr", ifid_instr, 16'(16'h1000 + i * 16'h0100));
            cyc();
        end
        @(negedge clk);
        chk("halt_hlt", {15'd0, hlt}, 16'd1);
        chk("halt_en", {15'd0, imem_en}, 16'd0);
        chk("halt_word", ifid_instr, 16'hF000);
        wait_cyc(2);
        @(negedge clk);
        chk("halt_hold_en", {15'd0, imem_en}, 16'd0);
        cyc();
        redir_valid = 1'b1; redir_pc = 16'h0000;
        cyc();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("unhalt_hlt", {15'd0, hlt}, 16'd0);
        chk("unhalt_pc", pc, 16'h0000);
        chk("unhalt_en", {15'd0, imem_en}, 16'd1);

        // Stall three cycles mid-stream at 0x0100.
        cyc();
        redir_valid = 1'b1; redir_pc = 16'h0100;
        cyc();
        redir_valid = 1'b0;
        wait_cyc(3);
        stall = 1'b1;
        @(negedge clk); chk("stall_frozen0", ifid_pc, 16'h0102);
        wait_cyc(2);
        @(negedge clk); chk("stall_frozen2", ifid_pc, 16'h0102);
        cyc();
        stall = 1'b0;
        cyc();
        @(negedge clk); chk("stall_resume", ifid_pc, 16'h0104);
        wait_cyc(2);
        @(negedge clk); chk("stall_next", ifid_pc, 16'h0106);

        // Redirect while stalled.
        cyc();
        stall = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0040;
        cyc();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("redir_stall_valid", {15'd0, ifid_valid}, 16'd0);
        chk("redir_stall_pc", pc, 16'h0040);
        cyc();
        stall = 1'b0;

        // Wrap at 0xFFFE.
        cyc();
        redir_valid = 1'b1; redir_pc = 16'hFFFE;
        cyc();
        redir_valid = 1'b0;
        @(negedge clk); chk("wrap_addr", imem_addr, 16'hFFFE);
        cyc();
        @(negedge clk); chk("wrap_pc", pc, 16'h0000);
        cyc();
        @(negedge clk);
        chk("wrap_ifid_pc", ifid_pc, 16'hFFFE);
        chk("wrap_plus2", ifid_pc_plus2, 16'h0000);

        // Backward branch at 0x0010.
        cyc();
        redir_valid = 1'b1; redir_pc = 16'h000A;
        cyc();
        redir_valid = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        chk("bb_ifid_pc", ifid_pc, 16'h0010);
        chk("bb_instr", ifid_instr, 16'hC1FE);
        chk("bb_pred", {15'd0, ifid_pred_taken}, {15'd0, BTFN});
        chk("bb_next_pc", pc, BTFN ? 16'h000E : 16'h0014);

        // Forward branch at 0x0020 is never predicted.
        cyc();
        redir_valid = 1'b1; redir_pc = 16'h001E;
        cyc();
        redir_valid = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        chk("fb_ifid_pc", ifid_pc, 16'h0020);
        chk("fb_pred", {15'd0, ifid_pred_taken}, 16'd0);
        chk("fb_next_pc", pc, 16'h0024);

        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst         = ($urandom_range(0, 299) == 0);
            stall       = ($urandom_range(0, 2) == 0);
            redir_valid = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 2))
                0:       redir_pc = 16'($urandom_range(0, 31) * 2);
                1:       redir_pc = 16'(16'h0200 + $urandom_range(0, 127) * 2);
                default: redir_pc = 16'(16'hFFF0 + $urandom_range(0, 7) * 2);
            endcase
        end
        cyc();
        rst = 1'b0; stall = 1'b0; redir_valid = 1'b0;
        wait_cyc(3);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: stall  input  1  hazard hold; IF/ID outputs and PC frozen.
REQ-005 SHALL have port: redir_valid  input  1  resolved-branch redirect from execute; also squashes IF/ID.
REQ-006 SHALL have port: redir_pc  input  16  redirect target PC.
REQ-007 SHALL have port: imem_en  output  1  instruction memory read enable.
REQ-008 SHALL have port: imem_addr  output  16  instruction memory byte address.
REQ-009 SHALL have port: imem_rdata  input  16  read data, valid exactly one cycle after imem_en.
REQ-010 SHALL have ports: ifid_valid  output  1; ifid_instr  output  16; ifid_pc  output  16; ifid_pc_plus2  output  16 (PCS data); ifid_pred_taken  output  1.
REQ-011 SHALL have ports: hlt  output  1  halted; pc  output  16  current fetch PC.

Function
REQ-012 SHALL keep a fetch PC register; imem_addr = pc; imem_en = 1 in RUN when stall=0, else 0.
REQ-013 SHALL advance pc by 16'd2 per issued fetch, wrapping 16'hFFFE -> 16'h0000.
REQ-014 SHALL track one in-flight request (valid bit + PC) and load returned data into IF/ID the following cycle: fetch-to-IF/ID latency 2 cycles.
REQ-015 SHALL implement states RUN, HOLD, HALT; HOLD = stall active while a returned word sits in the one-entry skid buffer.
REQ-016 RUN->HOLD when stall=1 and an in-flight word returns; HOLD->RUN when stall=0, skid drains into IF/ID that cycle, no fetch issued.
REQ-017 SHALL never drop or duplicate an instruction across any stall pattern; with stall=0 sustain one instruction per cycle.
REQ-018 SHALL enter HALT when a word with opcode 4'hF is loaded into IF/ID; in HALT imem_en=0, hlt=1, IF/ID holds the halt word valid.
REQ-019 redir_valid SHALL override stall and every state: next cycle pc=redir_pc, in-flight and skid discarded, ifid_valid=0, state=RUN, hlt=0.
REQ-020 ifid_pc_plus2 SHALL equal ifid_pc+2 modulo 2^16.
REQ-021 pc output SHALL equal the internal fetch PC every cycle.

Reset
REQ-022 On rst=1 at clk edge: pc=RESET_PC, state=RUN, in-flight/skid invalid, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pred_taken=0, hlt=0.
REQ-023 rst SHALL dominate redir_valid and stall; first fetch issues the cycle after rst deasserts.

Configuration
REQ-024 Macro FETCH_BTFN_EN SHALL enable backward-taken static prediction.
REQ-025 With FETCH_BTFN_EN: word loaded into IF/ID with opcode 4'hC and instr[8]=1 sets ifid_pred_taken=1, pc <= its PC+2+(sext(instr[8:0])<<1), in-flight word discarded (one bubble).
REQ-026 Without FETCH_BTFN_EN: ifid_pred_taken tied 0, fetch strictly sequential except redirects.

Structure
REQ-027 Shared package cpu_pkg SHALL hold OP_B=4'hC, OP_HLT=4'hF, PC width 16, fetch state enum.
REQ-028 Skid buffer SHALL be sub-module fetch_skid (1 entry, data+PC+valid, load/drain/clear).

Verification
REQ-029 Reset, imem returns 16'h1000,16'h1100,... -> IF/ID PCs 0,2,4 on consecutive cycles from cycle 2 after reset release.
REQ-030 stall high 3 cycles mid-stream -> IF/ID frozen, no loss/duplication; sequence resumes at next PC.
REQ-031 redir_valid=1, redir_pc=16'h0040 while stall=1 -> next cycle ifid_valid=0, pc=16'h0040; stall ignored.
REQ-032 Word 16'hF000 at PC 16'h0006 -> hlt=1, imem_en=0 held; later redirect to 16'h0000 -> hlt=0, fetching resumes.
REQ-033 FETCH_BTFN_EN, word 16'hC1FE at PC 16'h0010 -> ifid_pred_taken=1, next fetch PC 16'h000E; 16'hC002 -> pred 0, sequential.
REQ-034 Start pc=16'hFFFE -> next fetch 16'h0000, ifid_pc_plus2=16'h0000.
